// File: rtl/comparator_iterative_pkg.sv
// Shared definitions for the iterative magnitude comparator.
//   cmp_state_e : FSM state encoding (IDLE/BUSY/DONE)
//   clog2       : ceiling log2, used to size the chunk index
//   idx_width   : index register width, never less than one bit
package comparator_iterative_pkg;

  typedef enum logic [1:0] {
    CMP_IDLE = 2'd0,
    CMP_BUSY = 2'd1,
    CMP_DONE = 2'd2
  } cmp_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // NCHUNK=1 gives clog2=0; keep a one-bit index so the register stays legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
//   x, y : slice operands
//   eq   : x == y
//   gt   : x > y
//   lt   : x < y
module comparator_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (x == y);
  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/comparator_iterative.sv
// Multi-cycle magnitude comparator: compares a and b CHUNK bits per cycle, MSB chunk first.
// Signed compares are done by flipping the sign bits (offset binary) and comparing unsigned.
// Optional macro COMPARATOR_EARLY_EXIT_EN: finish on the first differing chunk instead of
// always scanning all chunks. Results are identical either way; only latency differs.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid, in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b, signed_mode    : operands and compare mode, sampled on accept
//   out_valid, out_ready : result handshake (result held while out_ready is low)
//   equal, greater, less : one-hot result, all zero outside DONE
//   busy                 : FSM not in IDLE
module comparator_iterative
  import comparator_iterative_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             equal,
  output logic             greater,
  output logic             less,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = idx_width(NCHUNK);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  cmp_state_e       state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx_q;
  logic             gt_q, lt_q;

  logic [CHUNK-1:0] ca, cb;
  logic             c_eq, c_gt, c_lt;
  logic             gt_nxt, lt_nxt;
  logic             scan_done;

  // Slice selection by compare rather than a variable part-select keeps widths explicit.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        ca = a_q[i*CHUNK +: CHUNK];
        cb = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  comparator_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .x (ca),
    .y (cb),
    .eq(c_eq),
    .gt(c_gt),
    .lt(c_lt)
  );

  // The first differing chunk decides; once a flag is set, later chunks are ignored.
  always_comb begin
    gt_nxt = gt_q;
    lt_nxt = lt_q;
    if (!gt_q && !lt_q && !c_eq) begin
      gt_nxt = c_gt;
      lt_nxt = c_lt;
    end
  end

`ifdef COMPARATOR_EARLY_EXIT_EN
  assign scan_done = (idx_q == '0) || !c_eq;
`else
  assign scan_done = (idx_q == '0);
`endif

  assign in_ready = (state_q == CMP_IDLE);
  assign busy     = (state_q != CMP_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CMP_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      out_valid <= 1'b0;
      equal     <= 1'b0;
      greater   <= 1'b0;
      less      <= 1'b0;
    end else begin
      unique case (state_q)
        CMP_IDLE: begin
          if (in_valid) begin
            a_q     <= signed_mode ? (a ^ MSB_MASK) : a;
            b_q     <= signed_mode ? (b ^ MSB_MASK) : b;
            idx_q   <= IW'(NCHUNK - 1);
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            state_q <= CMP_BUSY;
          end
        end
        CMP_BUSY: begin
          gt_q <= gt_nxt;
          lt_q <= lt_nxt;
          if (scan_done) begin
            state_q   <= CMP_DONE;
            out_valid <= 1'b1;
            equal     <= !gt_nxt && !lt_nxt;
            greater   <= gt_nxt;
            less      <= lt_nxt;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        CMP_DONE: begin
          if (out_ready) begin
            state_q   <= CMP_IDLE;
            out_valid <= 1'b0;
            equal     <= 1'b0;
            greater   <= 1'b0;
            less      <= 1'b0;
          end
        end
        default: begin
          state_q   <= CMP_IDLE;
          out_valid <= 1'b0;
          equal     <= 1'b0;
          greater   <= 1'b0;
          less      <= 1'b0;
        end
      endcase
    end
  end

endmodule
